// File: rtl/free_list_releaser_if.sv
`default_nettype none
// ============================================================================
// Module   : free_list_releaser_if
// Brief    : Retire-side and free-list-side handshake bundle for the
//            free list releaser (ROB T_old slots in, single PR enqueue out).
// Revision : 1.0 - initial release
// ============================================================================
interface free_list_releaser_if #(
   parameter int RETIRE_WIDTH = 2,
   parameter int PR_W         = 6
);
   logic [RETIRE_WIDTH-1:0]           retire_valid;
   logic [RETIRE_WIDTH-1:0][PR_W-1:0] retire_told;
   logic                              retire_stall;
   logic                              enqueue_en;
   logic [PR_W-1:0]                   enqueue_pr;
   logic                              was_enqueued;

   // The releaser: consumes retire slots, produces enqueue requests
   modport master (
      input  retire_valid, retire_told, was_enqueued,
      output retire_stall, enqueue_en, enqueue_pr
   );

   // The surroundings: ROB retire stage plus free_list enqueue port
   modport slave (
      output retire_valid, retire_told, was_enqueued,
      input  retire_stall, enqueue_en, enqueue_pr
   );
endinterface
`default_nettype wire

// File: rtl/free_list_releaser.sv
`default_nettype none
// ============================================================================
// Module   : free_list_releaser
// Brief    : Buffers stale physical registers (T_old) of retiring instructions
//            in a small FIFO and returns them to free_list one per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module free_list_releaser #(
   parameter int DEPTH           = 8,
   parameter int RETIRE_WIDTH    = 2,
   parameter int PHYS_REG_IDX_SZ = 5
) (
   input  wire logic                          clk,
   input  wire logic                          reset,
   free_list_releaser_if.master               bus,
   output logic [$clog2(DEPTH):0]             pending_count,
   output logic                               empty
);
   localparam int PR_W  = PHYS_REG_IDX_SZ + 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] RW_C    = CNT_W'(RETIRE_WIDTH);

   logic [PR_W-1:0]                    mem [DEPTH];
   logic [PTR_W-1:0]                   head;
   logic [PTR_W-1:0]                   tail;
   logic [CNT_W-1:0]                   count;
   logic [CNT_W-1:0]                   push_cnt;
   logic [RETIRE_WIDTH-1:0]            wr_en;
   logic [RETIRE_WIDTH-1:0][PTR_W-1:0] wr_idx;
   logic                               pop;

   // Compact the non-zero valid slots onto consecutive tail positions; a slot
   // only writes while room remains as seen from the registered count, so a
   // same-cycle pop never makes room for a push.
   always_comb begin
      push_cnt = '0;
      wr_en    = '0;
      wr_idx   = '0;
      for (int i = 0; i < RETIRE_WIDTH; i++) begin
         wr_idx[i] = tail + push_cnt[PTR_W-1:0];
         if (bus.retire_valid[i] && (bus.retire_told[i] != '0) &&
             ((count + push_cnt) < DEPTH_C)) begin
            wr_en[i] = 1'b1;
            push_cnt = push_cnt + CNT_W'(1);
         end
      end
   end

   // Everything visible to free_list and the ROB derives from registered state
   assign pop            = (count != '0) && bus.was_enqueued;
   assign bus.enqueue_en = (count != '0);
   assign bus.enqueue_pr = (count != '0) ? mem[head] : '0;
   assign bus.retire_stall = (DEPTH_C - count) < RW_C;
   assign pending_count  = count;
   assign empty          = (count == '0);

   // Pointer and occupancy update; reset discards anything buffered
   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + push_cnt[PTR_W-1:0];
         head  <= head + PTR_W'(pop);
         count <= count + push_cnt - CNT_W'(pop);
      end
   end

   // Entry storage; contents are meaningless unless covered by count
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= bus.retire_told[i];
         end
      end
   end

   // Retiring while stalled is a ROB protocol violation
   a_no_retire_on_stall : assert property (@(posedge clk) disable iff (reset)
      !(bus.retire_stall && (|bus.retire_valid)));

endmodule
`default_nettype wire

// File: tb/tb_free_list_releaser.sv
`default_nettype none
// ============================================================================
// Module   : tb_free_list_releaser
// Brief    : Scoreboard testbench for free_list_releaser.
// Revision : 1.0 - initial release
// ============================================================================
module tb_free_list_releaser;
   localparam int DEPTH = 8;
   localparam int RW    = 2;
   localparam int PRSZ  = 5;
   localparam int PR_W  = PRSZ + 1;

   logic clk = 1'b0;
   logic reset;
   logic [$clog2(DEPTH):0] pending_count;
   logic empty;

   int errors = 0;
   int checks = 0;
   logic [PR_W-1:0] sbq [$];

   free_list_releaser_if #(.RETIRE_WIDTH(RW), .PR_W(PR_W)) bus ();

   free_list_releaser #(.DEPTH(DEPTH), .RETIRE_WIDTH(RW), .PHYS_REG_IDX_SZ(PRSZ)) dut (
      .clk           (clk),
      .reset         (reset),
      .bus           (bus),
      .pending_count (pending_count),
      .empty         (empty)
   );

   always #5 clk = ~clk;

   // One clock: score any handshake at the current outputs, record retires,
   // drive inputs, then wait to the next falling edge
   task automatic cycle(input logic [1:0] v, input logic [PR_W-1:0] t0,
                        input logic [PR_W-1:0] t1, input logic ack);
      logic [PR_W-1:0] exp;
      if (ack && bus.enqueue_en) begin
         checks++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL pop_extra: got pr=%0d, required no output", bus.enqueue_pr);
         end else begin
            exp = sbq.pop_front();
            if (bus.enqueue_pr !== exp) begin
               errors++;
               $display("FAIL pop_order: got pr=%0d, required %0d", bus.enqueue_pr, exp);
            end
         end
      end
      if (v[0] && t0 != '0) sbq.push_back(t0);
      if (v[1] && t1 != '0) sbq.push_back(t1);
      bus.retire_valid   = v;
      bus.retire_told[0] = t0;
      bus.retire_told[1] = t1;
      bus.was_enqueued   = ack;
      @(negedge clk);
   endtask

   task automatic chk_count(input string name);
      checks++;
      if (pending_count !== ($clog2(DEPTH)+1)'(sbq.size())) begin
         errors++;
         $display("FAIL %s: got count=%0d, required %0d", name, pending_count, sbq.size());
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && bus.enqueue_en; i++) cycle(2'b00, '0, '0, 1'b1);
      checks++;
      if (empty !== 1'b1 || sbq.size() != 0) begin
         errors++;
         $display("FAIL drain: got empty=%b, required 1 with %0d left", empty, sbq.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.retire_valid = '0; bus.retire_told = '0; bus.was_enqueued = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if (bus.enqueue_en !== 1'b0 || bus.enqueue_pr !== '0 || bus.retire_stall !== 1'b0 ||
          pending_count !== '0 || empty !== 1'b1) begin
         errors++;
         $display("FAIL reset: got en=%b pr=%0d stall=%b cnt=%0d empty=%b, required 0 0 0 0 1",
                  bus.enqueue_en, bus.enqueue_pr, bus.retire_stall, pending_count, empty);
      end
   endtask

   task automatic test_single();
      cycle(2'b01, 6'd5, '0, 1'b0);
      checks++;
      if (bus.enqueue_en !== 1'b1 || bus.enqueue_pr !== 6'd5) begin
         errors++;
         $display("FAIL single_latency: got en=%b pr=%0d, required 1 5", bus.enqueue_en, bus.enqueue_pr);
      end
      cycle(2'b00, '0, '0, 1'b1);
      checks++;
      if (empty !== 1'b1 || bus.enqueue_en !== 1'b0) begin
         errors++;
         $display("FAIL single_empty: got empty=%b en=%b, required 1 0", empty, bus.enqueue_en);
      end
   endtask

   task automatic test_order();
      int peak = 0;
      cycle(2'b11, 6'd7, 6'd9, 1'b1);
      chk_count("order_cnt1");
      if (pending_count > peak) peak = pending_count;
      cycle(2'b11, 6'd11, 6'd0, 1'b1);
      chk_count("order_cnt2");
      if (pending_count > peak) peak = pending_count;
      for (int i = 0; i < 4; i++) begin
         cycle(2'b00, '0, '0, 1'b1);
         if (pending_count > peak) peak = pending_count;
      end
      checks++;
      if (peak != 2) begin
         errors++;
         $display("FAIL order_peak: got peak=%0d, required 2", peak);
      end
      drain();
   endtask

   task automatic test_back_to_back_backpressure();
      cycle(2'b11, 6'd20, 6'd21, 1'b0);
      cycle(2'b11, 6'd22, 6'd23, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cycle(2'b00, '0, '0, 1'b0);
         checks++;
         if (bus.enqueue_pr !== 6'd20 || pending_count !== 4'd4) begin
            errors++;
            $display("FAIL bp_hold: got pr=%0d cnt=%0d, required 20 4", bus.enqueue_pr, pending_count);
         end
      end
      for (int i = 0; i < 4; i++) cycle(2'b00, '0, '0, 1'b1);
      checks++;
      if (empty !== 1'b1 || sbq.size() != 0) begin
         errors++;
         $display("FAIL bp_drain: got empty=%b, required 1 with %0d left", empty, sbq.size());
      end
   endtask

   task automatic test_full_stall();
      cycle(2'b11, 6'd30, 6'd31, 1'b0);
      cycle(2'b11, 6'd32, 6'd33, 1'b0);
      cycle(2'b11, 6'd34, 6'd35, 1'b0);
      chk_count("full_cnt6");
      checks++;
      if (bus.retire_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_at6: got stall=%b, required 0", bus.retire_stall);
      end
      cycle(2'b01, 6'd36, '0, 1'b0);
      chk_count("full_cnt7");
      checks++;
      if (bus.retire_stall !== 1'b1) begin
         errors++;
         $display("FAIL stall_at7: got stall=%b, required 1", bus.retire_stall);
      end
      cycle(2'b00, '0, '0, 1'b1);
      chk_count("full_cnt_after_ack");
      checks++;
      if (bus.retire_stall !== 1'b0) begin
         errors++;
         $display("FAIL stall_drop: got stall=%b, required 0", bus.retire_stall);
      end
      drain();
   endtask

   task automatic test_wrap();
      int sent = 0;
      int cyc  = 0;
      logic [1:0] v;
      while ((sent < 20 || sbq.size() != 0) && cyc < 300) begin
         v = 2'b00;
         if (sent < 20 && !bus.retire_stall) begin
            v = 2'($urandom_range(1, 3));
            if (sent == 19) v = 2'b01;
         end
         cycle(v, 6'(40 + sent), 6'(40 + sent + (v[0] ? 1 : 0)), 1'($urandom_range(0, 1)));
         sent += (v[0] ? 1 : 0) + (v[1] ? 1 : 0);
         chk_count("wrap_cnt");
         cyc++;
      end
      checks++;
      if (cyc >= 300) begin
         errors++;
         $display("FAIL wrap_timeout: got %0d left after %0d cycles, required 0", sbq.size(), cyc);
      end
   endtask

   task automatic test_midop_reset();
      cycle(2'b11, 6'd50, 6'd51, 1'b0);
      cycle(2'b11, 6'd52, 6'd53, 1'b0);
      cycle(2'b01, 6'd54, '0, 1'b0);
      chk_count("mid_cnt5");
      bus.retire_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      sbq.delete();
      checks++;
      if (bus.enqueue_en !== 1'b0 || pending_count !== '0 || empty !== 1'b1 ||
          bus.retire_stall !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got en=%b cnt=%0d empty=%b stall=%b, required 0 0 1 0",
                  bus.enqueue_en, pending_count, empty, bus.retire_stall);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_order();
      test_back_to_back_backpressure();
      test_full_stall();
      test_wrap();
      test_midop_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
